// File: rtl/fan_pwm_pkg.sv
// Shared constants for the smart fan PWM generator.
// Default duty width, the tick count of one PWM period, the default
// prescale ratio, and named duty levels used by the controller and benches.
package fan_pwm_pkg;

   localparam int DEFAULT_DUTY_W   = 8;
   localparam int DEFAULT_PRESCALE = 16;
   localparam int PERIOD_TICKS     = 255;

   localparam logic [7:0] DUTY_OFF  = 8'd0;
   localparam logic [7:0] DUTY_HALF = 8'd128;
   localparam logic [7:0] DUTY_FULL = 8'd255;

endpackage

// File: rtl/fan_pwm_prescaler.sv
// Divides the system clock down to the PWM tick rate.
// Emits a one-clock tick every PRESCALE clocks; a synchronous restart puts
// the count back to zero so that a new PWM period always begins on a full
// tick interval.
module fan_pwm_prescaler
   import fan_pwm_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count;

   // Free-running divider that wraps after PRESCALE clocks or on restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (restart || (count == LAST))
         count <= '0;
      else
         count <= count + CNT_W'(1);
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/fan_pwm_generator.sv
// Fixed-frequency PWM generator for the smart fan controller.
// The duty command is latched only at a period boundary, so the output
// never produces runt pulses when the command changes mid-period.
// Optional build macro PWM_SLEW_LIMIT_EN: when defined, the latched duty
// moves by at most one LSB toward the command at each period start.
module fan_pwm_generator
   import fan_pwm_pkg::*;
#(
   parameter int DUTY_W   = DEFAULT_DUTY_W,
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_out,
   output logic              period_start
);

   localparam logic [DUTY_W-1:0] LAST_TICK = DUTY_W'((2 ** DUTY_W) - 2);

   logic              tick;
   logic              start;
   logic              first;
   logic [DUTY_W-1:0] cnt;
   logic [DUTY_W-1:0] duty_q;
   logic [DUTY_W-1:0] duty_load;
   logic [DUTY_W-1:0] cnt_next;
   logic [DUTY_W-1:0] duty_q_next;

   fan_pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (start),
      .tick    (tick)
   );

   // A period begins right after reset release or when the last tick expires
   assign start = first | (tick & (cnt == LAST_TICK));

`ifdef PWM_SLEW_LIMIT_EN
   // Step the latched duty one LSB toward the command to soften speed changes
   always_comb begin
      duty_load = duty_q;
      if (duty > duty_q)
         duty_load = duty_q + DUTY_W'(1);
      else if (duty < duty_q)
         duty_load = duty_q - DUTY_W'(1);
   end
`else
   // Take the command as-is at each period start
   always_comb begin
      duty_load = duty;
   end
`endif

   // Next-state values shared by the state registers and the output compare
   always_comb begin
      cnt_next    = cnt;
      duty_q_next = duty_q;
      if (start) begin
         cnt_next    = '0;
         duty_q_next = duty_load;
      end else if (tick) begin
         cnt_next = cnt + DUTY_W'(1);
      end
   end

   // Period state, latched duty and the registered glitch-free output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first        <= 1'b1;
         cnt          <= '0;
         duty_q       <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         first        <= 1'b0;
         cnt          <= cnt_next;
         duty_q       <= duty_q_next;
         pwm_out      <= (cnt_next < duty_q_next);
         period_start <= start;
      end
   end

endmodule

// File: tb/tb_fan_pwm_generator.sv
// Directed self-checking bench for fan_pwm_generator at default parameters
// (8-bit duty, PRESCALE 16, 4080-clock period).
// With PWM_SLEW_LIMIT_EN defined the slew-limited ramp is exercised instead.
module tb_fan_pwm_generator;
   import fan_pwm_pkg::*;

   localparam int PS         = 16;
   localparam int PERIOD_CLK = PERIOD_TICKS * PS;
   localparam int MAX_LEN    = 5000;

   logic       clk;
   logic       rst_n;
   logic [7:0] duty;
   logic       pwm_out;
   logic       period_start;

   int compared;
   int mismatched;
   int hi_cnt;
   int len;

   fan_pwm_generator #(
      .DUTY_W   (8),
      .PRESCALE (PS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .duty         (duty),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the design never produces period boundaries
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic rst_val, input logic [7:0] duty_val);
      rst_n = rst_val;
      duty  = duty_val;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called on the falling edge where period_start is seen; counts the high
   // clocks and the length of the period until the next period_start.
   // Optionally changes the duty command change_at clocks into the period.
   task automatic measurePeriod(input int change_at, input logic [7:0] new_duty,
                                output int high_cnt, output int length);
      high_cnt = 0;
      length   = 0;
      do begin
         if (pwm_out === 1'b1)
            high_cnt++;
         length++;
         if (length == change_at)
            duty = new_duty;
         @(negedge clk);
      end while (period_start !== 1'b1 && length < MAX_LEN);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

`ifndef PWM_SLEW_LIMIT_EN
      // Reset held with duty at half scale
      applyStimulus(1'b0, DUTY_HALF);
      repeat (3) @(negedge clk);
      checkOutput("reset_pwm", int'(pwm_out), 0);
      checkOutput("reset_period_start", int'(period_start), 0);

      // Release: first period begins on the first clock
      applyStimulus(1'b1, DUTY_HALF);
      @(negedge clk);
      checkOutput("first_period_start", int'(period_start), 1);
      checkOutput("first_pwm_rise", int'(pwm_out), 1);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("half_p1_high", hi_cnt, 2048);
      checkOutput("half_p1_len", len, PERIOD_CLK);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("half_p2_high", hi_cnt, 2048);
      checkOutput("half_p2_len", len, PERIOD_CLK);

      // Command zero right after a boundary: current period keeps half duty
      duty = DUTY_OFF;
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("half_p3_high", hi_cnt, 2048);

      // Three zero-duty periods, still with period_start pulses
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("off_p1_high", hi_cnt, 0);
      checkOutput("off_p1_len", len, PERIOD_CLK);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("off_p2_high", hi_cnt, 0);
      checkOutput("off_p2_len", len, PERIOD_CLK);
      duty = DUTY_FULL;
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("off_p3_high", hi_cnt, 0);
      checkOutput("off_p3_len", len, PERIOD_CLK);

      // Three full-duty periods, high across the boundaries too
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("full_p1_high", hi_cnt, PERIOD_CLK);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("full_p2_high", hi_cnt, PERIOD_CLK);
      duty = DUTY_HALF;
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("full_p3_high", hi_cnt, PERIOD_CLK);
      checkOutput("full_p3_len", len, PERIOD_CLK);

      // Duty changes 128 -> 64 mid-period: only the next period follows it
      measurePeriod(1000, 8'd64, hi_cnt, len);
      checkOutput("chg_cur_high", hi_cnt, 2048);
      checkOutput("chg_cur_len", len, PERIOD_CLK);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("chg_next_high", hi_cnt, 1024);
      checkOutput("chg_next_len", len, PERIOD_CLK);

      // Reset asserted during the high phase, away from any clock edge
      repeat (100) @(negedge clk);
      checkOutput("pre_reset_pwm", int'(pwm_out), 1);
      duty = 8'd200;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_pwm", int'(pwm_out), 0);
      checkOutput("async_reset_period_start", int'(period_start), 0);
      @(negedge clk);
      applyStimulus(1'b1, 8'd200);
      @(negedge clk);
      checkOutput("rerelease_period_start", int'(period_start), 1);
      measurePeriod(0, 8'd0, hi_cnt, len);
      checkOutput("d200_high", hi_cnt, 3200);
      checkOutput("d200_len", len, PERIOD_CLK);
`else
      // Reset, then step the command 0 -> 10
      applyStimulus(1'b0, DUTY_OFF);
      repeat (3) @(negedge clk);
      checkOutput("reset_pwm", int'(pwm_out), 0);
      checkOutput("reset_period_start", int'(period_start), 0);
      applyStimulus(1'b1, 8'd10);
      @(negedge clk);
      checkOutput("first_period_start", int'(period_start), 1);
      for (int p = 1; p <= 11; p++) begin
         measurePeriod(0, 8'd0, hi_cnt, len);
         checkOutput($sformatf("slew_p%0d_high", p), hi_cnt, ((p < 10) ? p : 10) * PS);
         checkOutput($sformatf("slew_p%0d_len", p), len, PERIOD_CLK);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
